// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package reg_wb_pkg;

  // Arbitration FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  // Register file holds indices 0..REG_COUNT-1; index 15 aliases the PC.
  localparam int         REG_COUNT            = 15;
  localparam logic [3:0] PC_IDX               = 4'hF;
  localparam int         STARVE_LIMIT_DEFAULT = 4;

  // True when the index addresses a real register-file entry.
  function automatic logic idx_writable(input logic [3:0] idx);
    return idx < 4'(REG_COUNT);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter.sv
// Arbitrates register-file writes between the pipeline writeback stage and
// an auxiliary (debug/loader) port. Pipe normally wins; aux is guaranteed a
// slot after STARVE_LIMIT consecutive lost cycles by holding the pipe once.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_en,
  input  logic [3:0]  pipe_dest,
  input  logic [31:0] pipe_result,
  input  logic        aux_valid,
  input  logic [3:0]  aux_dest,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  output logic        pipe_hold,
  output logic        writeBackEn,
  output logic [3:0]  dest_wb,
  output logic [31:0] Result_WB,
  output logic        aux_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  wait_cnt_inc;
  logic        aux_err_q, aux_err_d;
  logic        grant_pipe, grant_aux;

  // Next-state, starvation counter and grant decision.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    grant_pipe   = 1'b0;
    grant_aux    = 1'b0;
    wait_cnt_inc = wait_cnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (pipe_wb_en) begin
          grant_pipe = 1'b1;
          if (aux_valid) begin
            // First lost cycle; a limit of one forces on the very next cycle.
            wait_cnt_d = 4'd1;
            state_d    = (LIMIT <= 4'd1) ? FORCE : WAIT;
          end
        end else if (aux_valid) begin
          grant_aux = 1'b1;
        end
      end
      WAIT: begin
        if (!aux_valid) begin
          // Requester withdrew: no aux grant, the pipe still writes if present.
          grant_pipe = pipe_wb_en;
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else if (!pipe_wb_en) begin
          grant_aux  = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else begin
          grant_pipe = 1'b1;
          wait_cnt_d = wait_cnt_inc;
          state_d    = (wait_cnt_inc >= LIMIT) ? FORCE : WAIT;
        end
      end
      FORCE: begin
        // Pipe is held off; the aux request is still pending by protocol.
        grant_aux  = aux_valid;
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
    // Reset abandons any in-flight request within the same cycle.
    if (rst) begin
      grant_pipe = 1'b0;
      grant_aux  = 1'b0;
    end
  end

  // Single output mux toward the register file; zeros when nothing is granted.
  always_comb begin
    writeBackEn = 1'b0;
    dest_wb     = 4'd0;
    Result_WB   = 32'd0;
    if (grant_pipe) begin
      writeBackEn = idx_writable(pipe_dest);
      dest_wb     = pipe_dest;
      Result_WB   = pipe_result;
    end else if (grant_aux) begin
      writeBackEn = idx_writable(aux_dest);
      dest_wb     = aux_dest;
      Result_WB   = aux_data;
    end
  end

  assign aux_ready = grant_aux;
  assign pipe_hold = (state_q == FORCE) && !rst;
  assign aux_err_d = aux_err_q | (grant_aux && (aux_dest == PC_IDX));
  assign aux_err   = aux_err_q;

  // State, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      aux_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      aux_err_q  <= aux_err_d;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scenario-driven bench for reg_wb_arbiter with an expected-output queue.
module tb_reg_wb_arbiter;
  import reg_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [3:0]  pipe_dest;
  logic [31:0] pipe_result;
  logic        aux_valid;
  logic [3:0]  aux_dest;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        pipe_hold;
  logic        writeBackEn;
  logic [3:0]  dest_wb;
  logic [31:0] Result_WB;
  logic        aux_err;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_dest(pipe_dest), .pipe_result(pipe_result),
    .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_data(aux_data),
    .aux_ready(aux_ready), .pipe_hold(pipe_hold),
    .writeBackEn(writeBackEn), .dest_wb(dest_wb), .Result_WB(Result_WB),
    .aux_err(aux_err)
  );

  // {aux_ready, pipe_hold, writeBackEn, dest_wb, Result_WB, aux_err}
  logic [39:0] obs_vec;
  assign obs_vec = {aux_ready, pipe_hold, writeBackEn, dest_wb, Result_WB, aux_err};

  localparam logic [39:0] M_ALL   = {40{1'b1}};
  localparam logic [39:0] M_CTRL  = {3'b111, 4'h0, 32'h0, 1'b1};
  localparam logic [39:0] M_NOERR = {3'b111, 4'hF, 32'hFFFF_FFFF, 1'b0};

  typedef struct {
    logic [39:0] val;
    logic [39:0] mask;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input string nm, input logic ar, input logic ph,
                              input logic wen, input logic [3:0] d,
                              input logic [31:0] dat, input logic err,
                              input logic [39:0] m);
    exp_t e;
    e.val  = {ar, ph, wen, d, dat, err};
    e.mask = m;
    e.name = nm;
    return e;
  endfunction

  // Apply one cycle of stimulus just after posedge, return at the negedge.
  task automatic drive(input logic r, input logic pe, input logic [3:0] pd,
                       input logic [31:0] pr, input logic av,
                       input logic [3:0] ad, input logic [31:0] adat);
    @(posedge clk);
    #1;
    rst = r; pipe_wb_en = pe; pipe_dest = pd; pipe_result = pr;
    aux_valid = av; aux_dest = ad; aux_data = adat;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        sb_q.push_back(mk($sformatf("reset_c%0d", i), 0, 0, 0, 4'd0, 32'd0, 0, M_ALL));
        drive(1, 1, 4'd5, 32'h55, 1, 4'd6, 32'h66);
      end else begin
        sb_q.push_back(mk("reset_idle", 0, 0, 0, 4'd0, 32'd0, 0, M_ALL));
        drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
      end
      e = sb_q.pop_front();
      n_checks++;
      if ((obs_vec & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, obs_vec & e.mask, e.val & e.mask);
      end else $display("txn %s: out=%h", e.name, obs_vec);
      if (i == 1) begin
        n_checks++;
        if (dut.state_q !== IDLE || dut.wait_cnt_q !== 4'd0) begin
          n_fail++;
          $display("FAIL reset_state: got state=%0d cnt=%0d want state=0 cnt=0",
                   dut.state_q, dut.wait_cnt_q);
        end
      end
    end
  endtask

  task automatic test_aux_only();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        sb_q.push_back(mk("aux_only", 1, 0, 1, 4'd3, 32'hDEAD_BEEF, 0, M_ALL));
        drive(0, 0, 4'd0, 32'd0, 1, 4'd3, 32'hDEAD_BEEF);
      end else begin
        sb_q.push_back(mk("aux_only_idle", 0, 0, 0, 4'd0, 32'd0, 0, M_ALL));
        drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
      end
      e = sb_q.pop_front();
      n_checks++;
      if ((obs_vec & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, obs_vec & e.mask, e.val & e.mask);
      end else $display("txn %s: out=%h", e.name, obs_vec);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        sb_q.push_back(mk($sformatf("b2b_aux%0d", i), 1, 0, 1, 4'(10 + i),
                          32'h1000 + i, 0, M_ALL));
        drive(0, 0, 4'd0, 32'd0, 1, 4'(10 + i), 32'h1000 + i);
      end else begin
        sb_q.push_back(mk("b2b_idle", 0, 0, 0, 4'd0, 32'd0, 0, M_ALL));
        drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
      end
      e = sb_q.pop_front();
      n_checks++;
      if ((obs_vec & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, obs_vec & e.mask, e.val & e.mask);
      end else $display("txn %s: out=%h", e.name, obs_vec);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0, 1: begin
          sb_q.push_back(mk($sformatf("cont_pipe%0d", i), 0, 0, 1, 4'd5, 32'd7, 0, M_ALL));
          drive(0, 1, 4'd5, 32'd7, 1, 4'd2, 32'h2222);
        end
        2: begin
          sb_q.push_back(mk("cont_aux", 1, 0, 1, 4'd2, 32'h2222, 0, M_ALL));
          drive(0, 0, 4'd0, 32'd0, 1, 4'd2, 32'h2222);
        end
        default: begin
          sb_q.push_back(mk("cont_idle", 0, 0, 0, 4'd0, 32'd0, 0, M_ALL));
          drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        end
      endcase
      e = sb_q.pop_front();
      n_checks++;
      if ((obs_vec & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, obs_vec & e.mask, e.val & e.mask);
      end else $display("txn %s: out=%h", e.name, obs_vec);
      if (i == 1 || i == 3) begin
        n_checks++;
        if (dut.state_q !== ((i == 1) ? WAIT : IDLE) ||
            dut.wait_cnt_q !== ((i == 1) ? 4'd1 : 4'd0)) begin
          n_fail++;
          $display("FAIL cont_state%0d: got state=%0d cnt=%0d want state=%0d cnt=%0d",
                   i, dut.state_q, dut.wait_cnt_q, (i == 1) ? 1 : 0, (i == 1) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        1: begin
          // Pipe write to index 15 still wins and still counts as a lost aux cycle.
          sb_q.push_back(mk("starve_pipe15", 0, 0, 0, 4'd0, 32'd0, 0, M_CTRL));
          drive(0, 1, 4'd15, 32'h101, 1, 4'd9, 32'hA5A5);
        end
        0, 2, 3: begin
          sb_q.push_back(mk($sformatf("starve_pipe%0d", i), 0, 0, 1, 4'd6,
                            32'h100 + i, 0, M_ALL));
          drive(0, 1, 4'd6, 32'h100 + i, 1, 4'd9, 32'hA5A5);
        end
        4: begin
          sb_q.push_back(mk("starve_force", 1, 1, 1, 4'd9, 32'hA5A5, 0, M_ALL));
          drive(0, 1, 4'd6, 32'h104, 1, 4'd9, 32'hA5A5);
        end
        5: begin
          sb_q.push_back(mk("starve_repipe", 0, 0, 1, 4'd6, 32'h104, 0, M_ALL));
          drive(0, 1, 4'd6, 32'h104, 0, 4'd0, 32'd0);
        end
        default: begin
          sb_q.push_back(mk("starve_idle", 0, 0, 0, 4'd0, 32'd0, 0, M_ALL));
          drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        end
      endcase
      e = sb_q.pop_front();
      n_checks++;
      if ((obs_vec & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, obs_vec & e.mask, e.val & e.mask);
      end else $display("txn %s: out=%h", e.name, obs_vec);
      if (i == 4) begin
        n_checks++;
        if (dut.state_q !== FORCE) begin
          n_fail++;
          $display("FAIL starve_state: got state=%0d want state=%0d", dut.state_q, FORCE);
        end
      end
    end
  endtask

  task automatic test_index15();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin
          sb_q.push_back(mk("idx15_aux", 1, 0, 0, 4'd0, 32'd0, 0, M_CTRL));
          drive(0, 0, 4'd0, 32'd0, 1, 4'd15, 32'h5555);
        end
        2: begin
          sb_q.push_back(mk("idx15_pipe", 0, 0, 0, 4'd0, 32'd0, 1, M_CTRL));
          drive(0, 1, 4'd15, 32'h77, 0, 4'd0, 32'd0);
        end
        default: begin
          sb_q.push_back(mk($sformatf("idx15_idle%0d", i), 0, 0, 0, 4'd0, 32'd0, 1, M_ALL));
          drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        end
      endcase
      e = sb_q.pop_front();
      n_checks++;
      if ((obs_vec & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, obs_vec & e.mask, e.val & e.mask);
      end else $display("txn %s: out=%h", e.name, obs_vec);
    end
  endtask

  task automatic test_aux_drop();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          sb_q.push_back(mk("drop_pipe0", 0, 0, 1, 4'd4, 32'h40, 1, M_ALL));
          drive(0, 1, 4'd4, 32'h40, 1, 4'd8, 32'h80);
        end
        1: begin
          sb_q.push_back(mk("drop_pipe1", 0, 0, 1, 4'd4, 32'h41, 1, M_ALL));
          drive(0, 1, 4'd4, 32'h41, 0, 4'd0, 32'd0);
        end
        default: begin
          sb_q.push_back(mk("drop_idle", 0, 0, 0, 4'd0, 32'd0, 1, M_ALL));
          drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        end
      endcase
      e = sb_q.pop_front();
      n_checks++;
      if ((obs_vec & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, obs_vec & e.mask, e.val & e.mask);
      end else $display("txn %s: out=%h", e.name, obs_vec);
      if (i == 2) begin
        n_checks++;
        if (dut.state_q !== IDLE || dut.wait_cnt_q !== 4'd0) begin
          n_fail++;
          $display("FAIL drop_state: got state=%0d cnt=%0d want state=0 cnt=0",
                   dut.state_q, dut.wait_cnt_q);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 1: begin
          sb_q.push_back(mk($sformatf("rstw_pipe%0d", i), 0, 0, 1, 4'd5, 32'h50, 1, M_ALL));
          drive(0, 1, 4'd5, 32'h50, 1, 4'd2, 32'h20);
        end
        2: begin
          sb_q.push_back(mk("rstw_inrst", 0, 0, 0, 4'd0, 32'd0, 0, M_NOERR));
          drive(1, 1, 4'd5, 32'h50, 1, 4'd2, 32'h20);
        end
        3: begin
          sb_q.push_back(mk("rstw_pipe_after", 0, 0, 1, 4'd5, 32'h50, 0, M_ALL));
          drive(0, 1, 4'd5, 32'h50, 1, 4'd2, 32'h20);
        end
        4: begin
          sb_q.push_back(mk("rstw_aux", 1, 0, 1, 4'd2, 32'h20, 0, M_ALL));
          drive(0, 0, 4'd0, 32'd0, 1, 4'd2, 32'h20);
        end
        default: begin
          sb_q.push_back(mk("rstw_idle", 0, 0, 0, 4'd0, 32'd0, 0, M_ALL));
          drive(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        end
      endcase
      e = sb_q.pop_front();
      n_checks++;
      if ((obs_vec & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.name, obs_vec & e.mask, e.val & e.mask);
      end else $display("txn %s: out=%h", e.name, obs_vec);
      if (i == 2 || i == 3) begin
        n_checks++;
        if (dut.state_q !== ((i == 2) ? WAIT : IDLE) ||
            dut.wait_cnt_q !== ((i == 2) ? 4'd2 : 4'd0)) begin
          n_fail++;
          $display("FAIL rstw_state%0d: got state=%0d cnt=%0d want state=%0d cnt=%0d",
                   i, dut.state_q, dut.wait_cnt_q, (i == 2) ? 1 : 0, (i == 2) ? 2 : 0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; pipe_wb_en = 1'b0; pipe_dest = 4'd0; pipe_result = 32'd0;
    aux_valid = 1'b0; aux_dest = 4'd0; aux_data = 32'd0;
    test_reset();
    test_aux_only();
    test_back_to_back();
    test_contention();
    test_starvation();
    test_index15();
    test_aux_drop();
    test_reset_mid_wait();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
